// File: rtl/pkt_rx_ctrl.sv
// Packet receive controller: frames sop/eop beats into a 2**AWIDTH-word buffer, reports length and errors.
// Latency: write strobe, pkt_done_o and err_o appear one cycle after the accepted beat.
// Backpressure: ready_o drops after each stored packet until the sorter has raised and then released busy_i.
module pkt_rx_ctrl #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 4
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              val_i,
  input  logic              sop_i,
  input  logic              eop_i,
  input  logic              busy_i,
  output logic              ready_o,
  output logic              wr_en_o,
  output logic [AWIDTH-1:0] wr_addr_o,
  output logic [DWIDTH-1:0] wr_data_o,
  output logic              pkt_done_o,
  output logic [AWIDTH:0]   pkt_len_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    IDLE_S,
    RECV_S,
    DROP_S,
    WAIT_BUSY_S,
    WAIT_FREE_S
  } state_t;

  // Buffer capacity in words; cnt reaching this value means the buffer is full.
  localparam logic [AWIDTH:0] CAP = {1'b1, {AWIDTH{1'b0}}};

  state_t            state;
  state_t            state_nxt;
  logic [AWIDTH:0]   cnt;
  logic [AWIDTH:0]   cnt_nxt;
  logic              beat;
  logic              wr_nxt;
  logic [AWIDTH-1:0] addr_nxt;
  logic              done_nxt;
  logic              err_nxt;

  assign beat = val_i & ready_o;

  // State and word-counter register.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state <= IDLE_S;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state plus the per-beat write/done/error decisions.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_nxt    = 1'b0;
    addr_nxt  = '0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE_S, RECV_S, DROP_S: begin
        if (beat) begin
          if (sop_i) begin
            // A new packet always starts at address 0; restarting an
            // unfinished packet is flagged, recovering from DROP is not.
            err_nxt = (state == RECV_S);
            wr_nxt  = 1'b1;
            cnt_nxt = (AWIDTH+1)'(1);
            if (eop_i) begin
              done_nxt  = 1'b1;
              state_nxt = WAIT_BUSY_S;
            end else begin
              state_nxt = RECV_S;
            end
          end else if (state == RECV_S) begin
            if (cnt != CAP) begin
              wr_nxt   = 1'b1;
              addr_nxt = cnt[AWIDTH-1:0];
              cnt_nxt  = cnt + 1'b1;
              if (eop_i) begin
                done_nxt  = 1'b1;
                state_nxt = WAIT_BUSY_S;
              end
            end else begin
              // Buffer already full: this packet cannot be stored.
              err_nxt   = 1'b1;
              state_nxt = eop_i ? IDLE_S : DROP_S;
            end
          end else if (state == DROP_S) begin
            if (eop_i) begin
              state_nxt = IDLE_S;
            end
          end else begin
            // Mid-packet word with no packet open.
            err_nxt = 1'b1;
          end
        end
      end
      WAIT_BUSY_S: begin
        if (busy_i) begin
          state_nxt = WAIT_FREE_S;
        end
      end
      WAIT_FREE_S: begin
        if (!busy_i) begin
          state_nxt = IDLE_S;
        end
      end
      default: begin
        state_nxt = IDLE_S;
      end
    endcase
  end

  // Input is accepted only while no stored packet is awaiting the sorter.
  always_comb begin
    ready_o = (state == IDLE_S) || (state == RECV_S) || (state == DROP_S);
  end

  // Registered buffer-write and status outputs; address/data hold between writes.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_en_o    <= 1'b0;
      wr_addr_o  <= '0;
      wr_data_o  <= '0;
      pkt_done_o <= 1'b0;
      pkt_len_o  <= '0;
      err_o      <= 1'b0;
    end else begin
      wr_en_o    <= wr_nxt;
      pkt_done_o <= done_nxt;
      err_o      <= err_nxt;
      if (wr_nxt) begin
        wr_addr_o <= addr_nxt;
        wr_data_o <= data_i;
      end
      if (done_nxt) begin
        pkt_len_o <= cnt_nxt;
      end
    end
  end

endmodule

// File: tb/tb_pkt_rx_ctrl.sv
module tb_pkt_rx_ctrl;

  logic        clk;
  logic        srst;
  logic [15:0] data;
  logic        val;
  logic        sop;
  logic        eop;
  logic        busy;
  logic        ready_o;
  logic        wr_en_o;
  logic [3:0]  wr_addr_o;
  logic [15:0] wr_data_o;
  logic        pkt_done_o;
  logic [4:0]  pkt_len_o;
  logic        err_o;

  int nvec = 0;
  int nerr = 0;

  // Reference model: packet-level bookkeeping.
  bit          m_inpkt;   // a packet is open and being stored
  bit          m_drop;    // rest of an oversized packet is being skipped
  int          m_hs;      // sorter handshake: 0 none, 1 await busy high, 2 await busy low
  int          m_words;   // words stored for the open packet
  logic        e_en, e_done, e_err;
  logic [3:0]  e_addr;
  logic [15:0] e_data;
  logic [4:0]  e_len;

  pkt_rx_ctrl #(.DWIDTH(16), .AWIDTH(4)) dut (
    .clk_i      (clk),
    .srst_i     (srst),
    .data_i     (data),
    .val_i      (val),
    .sop_i      (sop),
    .eop_i      (eop),
    .busy_i     (busy),
    .ready_o    (ready_o),
    .wr_en_o    (wr_en_o),
    .wr_addr_o  (wr_addr_o),
    .wr_data_o  (wr_data_o),
    .pkt_done_o (pkt_done_o),
    .pkt_len_o  (pkt_len_o),
    .err_o      (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish (observed running, expected done)");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_inpkt = 0; m_drop = 0; m_hs = 0; m_words = 0;
    e_en = 0; e_done = 0; e_err = 0; e_addr = '0; e_data = '0; e_len = '0;
  endtask

  task automatic model_store(input int addr, input logic [15:0] d);
    e_en   = 1'b1;
    e_addr = addr[3:0];
    e_data = d;
  endtask

  task automatic model_step(input bit r, input bit v, input bit s, input bit e,
                            input bit b, input logic [15:0] d);
    if (r) begin
      model_reset();
      return;
    end
    e_en = 0; e_done = 0; e_err = 0;
    if (m_hs == 1) begin
      if (b) m_hs = 2;
    end else if (m_hs == 2) begin
      if (!b) m_hs = 0;
    end else if (v) begin
      if (s) begin
        e_err   = m_inpkt;
        m_drop  = 0;
        m_words = 1;
        model_store(0, d);
        if (e) begin
          e_done = 1; e_len = 5'd1; m_hs = 1; m_inpkt = 0;
        end else begin
          m_inpkt = 1;
        end
      end else if (m_inpkt) begin
        if (m_words < 16) begin
          model_store(m_words, d);
          m_words++;
          if (e) begin
            e_done = 1; e_len = m_words[4:0]; m_hs = 1; m_inpkt = 0;
          end
        end else begin
          e_err   = 1;
          m_inpkt = 0;
          m_drop  = !e;
        end
      end else if (m_drop) begin
        if (e) m_drop = 0;
      end else begin
        e_err = 1;
      end
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, check ready, advance
  // the model, then check the registered outputs at the next falling edge.
  task automatic step(input bit r, input bit v, input bit s, input bit e,
                      input bit b, input logic [15:0] d);
    srst = r; val = v; sop = s; eop = e; busy = b; data = d;
    #1;
    chk("ready_o", {31'd0, ready_o}, {31'd0, (m_hs == 0)});
    model_step(r, v, s, e, b, d);
    @(negedge clk);
    chk("wr_en_o", {31'd0, wr_en_o}, {31'd0, e_en});
    chk("wr_addr_o", {28'd0, wr_addr_o}, {28'd0, e_addr});
    chk("wr_data_o", {16'd0, wr_data_o}, {16'd0, e_data});
    chk("pkt_done_o", {31'd0, pkt_done_o}, {31'd0, e_done});
    chk("pkt_len_o", {27'd0, pkt_len_o}, {27'd0, e_len});
    chk("err_o", {31'd0, err_o}, {31'd0, e_err});
  endtask

  task automatic send(input int n, input logic [15:0] base, input bit with_eop);
    for (int i = 0; i < n; i++) begin
      step(0, 1, (i == 0), with_eop && (i == n - 1), 0, base + 16'(i));
    end
  endtask

  task automatic handshake();
    step(0, 0, 0, 0, 1, 16'h0);
    step(0, 0, 0, 0, 0, 16'h0);
  endtask

  initial begin
    bit b;
    srst = 1; val = 0; sop = 0; eop = 0; busy = 0; data = '0;
    repeat (2) @(negedge clk);
    model_reset();
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    chk("rst_wr_en", {31'd0, wr_en_o}, 32'd0);
    chk("rst_addr", {28'd0, wr_addr_o}, 32'd0);
    chk("rst_data", {16'd0, wr_data_o}, 32'd0);
    chk("rst_done", {31'd0, pkt_done_o}, 32'd0);
    chk("rst_len", {27'd0, pkt_len_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    step(0, 0, 0, 0, 0, 16'h0);

    // 5-word packet, then ready stays low until busy rises and falls.
    send(5, 16'h0011, 1);
    chk("p5_done", {31'd0, pkt_done_o}, 32'd1);
    chk("p5_len", {27'd0, pkt_len_o}, 32'd5);
    chk("p5_last", {16'd0, wr_data_o}, 32'h15);
    repeat (3) step(0, 0, 0, 0, 0, 16'h0);
    chk("p5_ready_held", {31'd0, ready_o}, 32'd0);
    handshake();
    chk("p5_ready_back", {31'd0, ready_o}, 32'd1);

    // Single-beat packet.
    step(0, 1, 1, 1, 0, 16'h00AB);
    chk("p1_len", {27'd0, pkt_len_o}, 32'd1);
    chk("p1_addr", {28'd0, wr_addr_o}, 32'd0);
    handshake();

    // Exact-capacity packet completes normally.
    send(16, 16'h0100, 1);
    chk("p16_len", {27'd0, pkt_len_o}, 32'd16);
    chk("p16_addr", {28'd0, wr_addr_o}, 32'd15);
    handshake();

    // Oversized packet: 16 writes, error on 17th, back to idle, no done.
    send(17, 16'h0200, 1);
    chk("p17_err", {31'd0, err_o}, 32'd1);
    chk("p17_done", {31'd0, pkt_done_o}, 32'd0);
    chk("p17_ready", {31'd0, ready_o}, 32'd1);

    // Oversized packet continuing into DROP, then eop, then a clean packet.
    send(18, 16'h0300, 0);
    step(0, 1, 0, 1, 0, 16'h0399);
    send(2, 16'h0400, 1);
    handshake();

    // Restart: 3 words, then a fresh 2-word packet.
    send(3, 16'h0500, 0);
    send(2, 16'h0600, 1);
    chk("restart_len", {27'd0, pkt_len_o}, 32'd2);
    handshake();

    // Orphan beat in idle; beat during handshake wait is ignored.
    step(0, 1, 0, 0, 0, 16'h0777);
    chk("orphan_err", {31'd0, err_o}, 32'd1);
    step(0, 1, 1, 1, 0, 16'h0778);
    step(0, 1, 1, 1, 0, 16'h0779);
    chk("wait_no_wr", {31'd0, wr_en_o}, 32'd0);
    chk("wait_no_err", {31'd0, err_o}, 32'd0);
    handshake();

    // Reset mid-packet, then a 4-word packet.
    send(2, 16'h0800, 0);
    step(1, 0, 0, 0, 0, 16'h0);
    chk("mid_rst_wr", {31'd0, wr_en_o}, 32'd0);
    chk("mid_rst_len", {27'd0, pkt_len_o}, 32'd0);
    send(4, 16'h0900, 1);
    chk("p4_len", {27'd0, pkt_len_o}, 32'd4);
    handshake();

    // Random traffic against the model.
    b = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) b = ~b;
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 14) == 0),
           b,
           16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
